// File: rtl/bus_initiator_if.sv
// bus_initiator_if: command/response handshake and responder bus between a requester and bus_initiator.
interface bus_initiator_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [31:0] address_bus;
    logic [31:0] data_write_bus;
    logic [31:0] data_read_bus;
    logic        write_assert;
    logic        read_assert;
    logic        busy;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_data, rsp_ready, data_read_bus,
        output cmd_ready, rsp_valid, rsp_data, address_bus, data_write_bus, write_assert, read_assert, busy
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_data, rsp_ready, data_read_bus,
        input  cmd_ready, rsp_valid, rsp_data, address_bus, data_write_bus, write_assert, read_assert, busy
    );
endinterface

// File: rtl/bus_initiator.sv
// bus_initiator: queues read/write commands in a FIFO and replays them as strobed bus cycles.
module bus_initiator #(
    parameter int READ_WAIT  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input logic             clk,
    input logic             rst,
    bus_initiator_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    state_t        state, state_nx;
    logic [3:0]    wait_cnt, wait_nx;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          fifo_write [FIFO_DEPTH];
    logic [31:0]   fifo_addr  [FIFO_DEPTH];
    logic [31:0]   fifo_data  [FIFO_DEPTH];
    logic          push, pop, last;

    // Ready ignores a same-cycle pop so a full FIFO never takes a push.
    assign bus.cmd_ready    = count != FULL;
    assign push             = bus.cmd_valid && bus.cmd_ready;
    assign pop              = state == IDLE && count != '0;
    assign last             = wait_cnt == 4'(READ_WAIT);
    assign bus.write_assert = state == WRITE;
    assign bus.read_assert  = state == READ;
    assign bus.rsp_valid    = state == RESP;
    assign bus.busy         = state != IDLE || count != '0;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_write[wr_ptr] <= bus.cmd_write;
            fifo_addr[wr_ptr]  <= bus.cmd_addr;
            fifo_data[wr_ptr]  <= bus.cmd_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
        end
    end

    always_comb begin
        state_nx = state;
        wait_nx  = wait_cnt;
        case (state)
            IDLE: begin
                wait_nx = '0;
                if (pop) state_nx = fifo_write[rd_ptr] ? WRITE : READ;
            end
            WRITE: state_nx = IDLE;
            READ: begin
                wait_nx  = last ? 4'd0 : wait_cnt + 4'd1;
                state_nx = last ? RESP : READ;
            end
            RESP: state_nx = bus.rsp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    // Bus address/data are latched at pop and held until the next command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.address_bus    <= '0;
            bus.data_write_bus <= '0;
            bus.rsp_data       <= '0;
        end else begin
            if (pop) begin
                bus.address_bus    <= fifo_addr[rd_ptr];
                bus.data_write_bus <= fifo_write[rd_ptr] ? fifo_data[rd_ptr] : 32'h0;
            end
            if (state == READ && last) bus.rsp_data <= bus.data_read_bus;
        end
    end
endmodule

// File: tb/tb_bus_initiator.sv
// tb_bus_initiator: directed and mixed command streams checked by a queue scoreboard and bus monitor.
module tb_bus_initiator;
    localparam int RW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rnd = 1'b0;
    always #5 clk = ~clk;

    bus_initiator_if bus();
    bus_initiator #(.READ_WAIT(RW), .FIFO_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus.master));

    logic [31:0] resp_mem [256];
    logic [31:0] model    [256];
    logic [63:0] wq [$];
    logic [31:0] rq [$];
    logic [63:0] mon_w;
    logic [31:0] mon_r;
    int n_chk = 0;
    int n_fail = 0;

    // Responder: combinational read data, writes land on the strobe edge.
    always_comb bus.data_read_bus = bus.read_assert ? resp_mem[bus.address_bus[9:2]] : 32'h0;
    always @(posedge clk) if (bus.write_assert) resp_mem[bus.address_bus[9:2]] <= bus.data_write_bus;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.write_assert || bus.read_assert)
                chkb("strobe_overlap", bus.write_assert && bus.read_assert, 1'b0);
            if (bus.read_assert) chk("read_dwb_zero", bus.data_write_bus, 32'h0);
            if (bus.write_assert) begin
                chkb("write_expected", wq.size() != 0, 1'b1);
                if (wq.size() != 0) begin
                    mon_w = wq.pop_front();
                    chk("write_addr", bus.address_bus, mon_w[63:32]);
                    chk("write_data", bus.data_write_bus, mon_w[31:0]);
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                chkb("rsp_expected", rq.size() != 0, 1'b1);
                if (rq.size() != 0) begin
                    mon_r = rq.pop_front();
                    chk("rsp_data", bus.rsp_data, mon_r);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
        int t = 0;
        logic rdy;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_data  = d;
        do begin
            if (rnd) bus.rsp_ready = 1'($urandom_range(0, 1));
            rdy = bus.cmd_ready;
            step();
            t++;
        end while (!rdy && t < 200);
        bus.cmd_valid = 1'b0;
        chkb("cmd_accept", rdy, 1'b1);
        if (rdy) begin
            if (w) begin
                wq.push_back({a, d});
                model[a[9:2]] = d;
            end else rq.push_back(model[a[9:2]]);
        end
    endtask

    task automatic wait_rsp();
        int t = 0;
        while (!bus.rsp_valid && t < 50) begin
            step();
            t++;
        end
        chkb("rsp_seen", bus.rsp_valid, 1'b1);
    endtask

    task automatic drain();
        int t = 0;
        while ((wq.size() != 0 || rq.size() != 0 || bus.busy) && t < 400) begin
            step();
            t++;
        end
        chkb("drain", wq.size() == 0 && rq.size() == 0 && !bus.busy, 1'b1);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h0;
        bus.cmd_data  = 32'h0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            resp_mem[i] = 32'h1000_0000 | 32'(i);
            model[i]    = 32'h1000_0000 | 32'(i);
        end
        resp_mem[3] = 32'h155;
        model[3]    = 32'h155;

        step();
        chkb("rst_cmd_ready", bus.cmd_ready, 1'b1);
        chkb("rst_busy", bus.busy, 1'b0);
        chkb("rst_strobes", bus.write_assert || bus.read_assert, 1'b0);
        chkb("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_addr", bus.address_bus, 32'h0);
        chk("rst_wdata", bus.data_write_bus, 32'h0);
        chk("rst_rdata", bus.rsp_data, 32'h0);
        rst = 1'b0;
        step();

        // Single write: strobe in cycle 2 only.
        issue(1'b1, 32'h4, 32'h3FF);
        chkb("wr_c1", bus.write_assert, 1'b0);
        step();
        chkb("wr_c2", bus.write_assert, 1'b1);
        chk("wr_c2_addr", bus.address_bus, 32'h4);
        chk("wr_c2_data", bus.data_write_bus, 32'h3FF);
        step();
        chkb("wr_c3", bus.write_assert, 1'b0);
        chkb("wr_no_rsp", bus.rsp_valid, 1'b0);
        step();

        // Single read: strobe cycles 2..2+RW, response cycle 3+RW.
        issue(1'b0, 32'hC, 32'h0);
        for (int k = 1; k <= 4 + RW; k++) begin
            chkb("rd_strobe", bus.read_assert, k >= 2 && k <= 2 + RW);
            chkb("rd_rsp_valid", bus.rsp_valid, k == 3 + RW);
            if (k == 3 + RW) chk("rd_c_data", bus.rsp_data, 32'h155);
            if (k < 4 + RW) step();
        end

        // Stalled response holds data and blocks the queued write.
        bus.rsp_ready = 1'b0;
        issue(1'b0, 32'h10, 32'h0);
        issue(1'b1, 32'h20, 32'hCAFE_0001);
        wait_rsp();
        for (int k = 0; k < 10; k++) begin
            chkb("stall_valid", bus.rsp_valid, 1'b1);
            chk("stall_data", bus.rsp_data, 32'h1000_0004);
            chkb("stall_no_write", bus.write_assert, 1'b0);
            step();
        end
        bus.rsp_ready = 1'b1;
        drain();

        // FIFO fills while the FSM sits in RESP.
        bus.rsp_ready = 1'b0;
        issue(1'b0, 32'h24, 32'h0);
        wait_rsp();
        for (int i = 0; i < 4; i++) issue(1'b1, 32'h40 + 32'(4 * i), 32'hA0 + 32'(i));
        chkb("full_ready", bus.cmd_ready, 1'b0);
        repeat (3) step();
        chkb("full_hold", bus.cmd_ready, 1'b0);
        chkb("full_busy", bus.busy, 1'b1);
        bus.rsp_ready = 1'b1;
        issue(1'b1, 32'h50, 32'hA4);
        drain();

        // Reset in the middle of a read with two commands queued.
        issue(1'b0, 32'h30, 32'h0);
        issue(1'b1, 32'h3F0, 32'h1);
        issue(1'b1, 32'h3F4, 32'h2);
        chkb("abort_pre_read", bus.read_assert, 1'b1);
        #2 rst = 1'b1;
        #1;
        chkb("abort_read_drop", bus.read_assert, 1'b0);
        chkb("abort_cmd_ready", bus.cmd_ready, 1'b1);
        chkb("abort_busy", bus.busy, 1'b0);
        chkb("abort_rsp_valid", bus.rsp_valid, 1'b0);
        wq.delete();
        rq.delete();
        step();
        rst = 1'b0;
        repeat (10) step();
        chkb("abort_idle", bus.busy, 1'b0);

        // Mixed stream with random response back-pressure.
        rnd = 1'b1;
        for (int i = 0; i < 40; i++)
            issue(1'($urandom_range(0, 1)), {26'b0, 4'($urandom_range(0, 15)), 2'b00}, $urandom);
        rnd = 1'b0;
        bus.rsp_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_initiator.md
BUS_INITIATOR -- requirements
Module: bus_initiator

Interface
REQ-001 Parameter READ_WAIT, default 0: extra cycles ReadAssert is held before DataReadBus is sampled (0..15).
REQ-002 Parameter FIFO_DEPTH, default 4: command FIFO entries (power of two, 2..16).
REQ-003 CoreClock  in  1  single clock; all state changes on its rising edge.
REQ-004 Reset  in  1  asynchronous, active-high reset.
REQ-005 CmdValid  in  1  requester presents a command.
REQ-006 CmdReady  out  1  FIFO can accept a command.
REQ-007 CmdWrite  in  1  1 = bus write, 0 = bus read.
REQ-008 CmdAddr  in  32  target bus address.
REQ-009 CmdData  in  32  write data; ignored for reads.
REQ-010 RspValid  out  1  read result available.
REQ-011 RspReady  in  1  requester accepts the read result.
REQ-012 RspData  out  32  captured read data.
REQ-013 AddressBus  out  32  address driven to responders.
REQ-014 DataWriteBus  out  32  write data driven to responders.
REQ-015 DataReadBus  in  32  combinational read data from the addressed responder.
REQ-016 WriteAssert  out  1  one-cycle write strobe.
REQ-017 ReadAssert  out  1  read strobe.
REQ-018 Busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.

Function
REQ-019 Command accepted on a rising edge where CmdValid and CmdReady are both 1; {CmdWrite, CmdAddr, CmdData} pushed into the FIFO.
REQ-020 CmdReady = FIFO not full; independent of a same-cycle pop (no push-when-full, even if a pop occurs that cycle).
REQ-021 FIFO order is strict FIFO; no bypass; an entry pushed at edge N is poppable no earlier than the cycle after edge N.
REQ-022 FSM states: IDLE, WRITE, READ, RESP.
REQ-023 IDLE: if FIFO non-empty, pop head, latch address/data, go to WRITE (CmdWrite=1) or READ (CmdWrite=0); else stay.
REQ-024 WRITE: WriteAssert=1 for exactly one cycle with latched AddressBus/DataWriteBus; next state IDLE; no response generated.
REQ-025 READ: ReadAssert=1 for READ_WAIT+1 consecutive cycles with latched AddressBus; 4-bit wait counter counts 0..READ_WAIT; on the final cycle DataReadBus is registered into RspData; next state RESP.
REQ-026 RESP: RspValid=1, RspData stable until RspReady=1 is sampled; then IDLE; ReadAssert and WriteAssert are 0.
REQ-027 WriteAssert and ReadAssert are never high in the same cycle; both are 0 in IDLE and RESP.
REQ-028 AddressBus/DataWriteBus hold their last latched value outside WRITE/READ; DataWriteBus is 0 during reads.
REQ-029 Latency: command accepted at edge 0 into an empty FIFO with FSM in IDLE -> strobe first high in cycle 2 (after edge 1 pop); read response RspValid first high in cycle 3+READ_WAIT.
REQ-030 Back-to-back writes sustain one write per 2 cycles; FIFO keeps accepting while a read stalls in RESP until full.
REQ-031 FIFO pointers wrap modulo FIFO_DEPTH; occupancy counter ranges 0..FIFO_DEPTH.

Reset
REQ-032 On Reset: FSM to IDLE, FIFO emptied (contents discarded), wait counter 0; AddressBus, DataWriteBus, RspData = 0; WriteAssert, ReadAssert, RspValid, Busy = 0; CmdReady = 1 immediately.
REQ-033 Reset mid-transaction aborts it with no further strobe; an in-flight read response is lost.

Verification
REQ-034 Single write A=0x0004, D=0x03FF, READ_WAIT=0 -> WriteAssert high exactly cycle 2 with AddressBus=0x0004, DataWriteBus=0x03FF; RspValid stays 0.
REQ-035 Read A=0x000C, DataReadBus=0x0000_0155, READ_WAIT=2, RspReady=1 -> ReadAssert high cycles 2-4; RspValid high cycle 5, RspData=0x155.
REQ-036 Push 5 writes back-to-back with FSM held in RESP (RspReady=0 after a prior read), FIFO_DEPTH=4 -> CmdReady drops after 4th accept; 5th held until RspReady; all 5 writes appear in order.
REQ-037 Read then RspReady held 0 for 10 cycles -> RspValid and RspData stable 10 cycles; no new strobe until accept.
REQ-038 Assert Reset during READ with READ_WAIT=3 and 2 queued commands -> ReadAssert drops asynchronously, no RspValid, queued commands never issued, CmdReady=1.
REQ-039 Mixed random write/read stream against a scoreboard model -> strobes never overlap, order preserved, read data matches model.
